// File: rtl/s2p_receiver.sv
// Serial-to-parallel receiver for the s_clk/s_clrn/sin link.
// Oversamples the link in the clk domain, assembles DATA_BITS bits and strobes valid per word.
module s2p_receiver #(
    parameter int DATA_BITS   = 64,
    parameter bit DIR         = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 255,
    parameter int CNT_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_clrn,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] PData,
    output logic                 valid,
    output logic                 busy,
    output logic                 err
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0]      LAST_BIT = BCW'(DATA_BITS - 1);
    localparam logic [CNT_BITS-1:0] TMO_MAX  = CNT_BITS'(IDLE_CYCLES);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync_reg, clrn_sync_reg, sin_sync_reg;
    logic                   sclk_dly_reg;
    logic                   sclk_s, clrn_s, sin_s, fall, any_edge;

    logic [DATA_BITS-1:0] shift_reg, shift_next, shifted;
    logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [CNT_BITS-1:0]  tmo_reg, tmo_next;
    logic [DATA_BITS-1:0] pdata_reg, pdata_next;
    logic                 valid_reg, valid_next;
    logic                 err_reg, err_next;

    // All three inputs share the same depth so they stay mutually aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= '1;
            clrn_sync_reg <= '1;
            sin_sync_reg  <= '0;
            sclk_dly_reg  <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], s_clk};
            clrn_sync_reg <= {clrn_sync_reg[SYNC_STAGES-2:0], s_clrn};
            sin_sync_reg  <= {sin_sync_reg[SYNC_STAGES-2:0], sin};
            sclk_dly_reg  <= sclk_sync_reg[SYNC_STAGES-1];
        end
    end

    assign sclk_s   = sclk_sync_reg[SYNC_STAGES-1];
    assign clrn_s   = clrn_sync_reg[SYNC_STAGES-1];
    assign sin_s    = sin_sync_reg[SYNC_STAGES-1];
    assign fall     = sclk_dly_reg & ~sclk_s;
    assign any_edge = sclk_dly_reg ^ sclk_s;

    generate
        if (DATA_BITS == 1) begin : g_one
            assign shifted = sin_s;
        end else if (DIR) begin : g_lsb_first
            assign shifted = {sin_s, shift_reg[DATA_BITS-1:1]};
        end else begin : g_msb_first
            assign shifted = {shift_reg[DATA_BITS-2:0], sin_s};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tmo_reg     <= '0;
            pdata_reg   <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tmo_reg     <= tmo_next;
            pdata_reg   <= pdata_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
        end
    end

    // Priority: clear, then falling edge, then any edge, then timeout.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        tmo_next     = '0;
        pdata_next   = pdata_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        if (!clrn_s) begin
            state_next   = IDLE;
            shift_next   = '0;
            bit_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    state_next = IDLE;
                    if (fall) begin
                        shift_next   = shifted;
                        bit_cnt_next = BCW'(1);
                        if (DATA_BITS == 1) begin
                            state_next = DONE;
                            pdata_next = shifted;
                            valid_next = 1'b1;
                        end else begin
                            state_next = RECV;
                        end
                    end
                end
                RECV: begin
                    if (fall) begin
                        shift_next   = shifted;
                        bit_cnt_next = bit_cnt_reg + BCW'(1);
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = DONE;
                            pdata_next = shifted;
                            valid_next = 1'b1;
                        end
                    end else if (any_edge) begin
                        tmo_next = '0;
                    end else if (tmo_reg == TMO_MAX) begin
                        err_next     = 1'b1;
                        state_next   = IDLE;
                        shift_next   = '0;
                        bit_cnt_next = '0;
                    end else if (sclk_s) begin
                        tmo_next = tmo_reg + CNT_BITS'(1);
                    end else begin
                        tmo_next = tmo_reg;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // PData and valid are registered together on entry to DONE, so they line up.
    assign PData = pdata_reg;
    assign valid = valid_reg;
    assign err   = err_reg;
    assign busy  = (state_reg == RECV);

endmodule
